ita_softmax_div: RTL and testbench
==================================

Name: ita_softmax_div

Overview:
- Bank of NumDiv independent radix-2 restoring serial dividers. Each lane computes the softmax normalisation reciprocal, q = floor(2^DividendExp / d), where d is the final row exponent sum.
- Sits directly downstream of the softmax accumulation stage. It consumes the row sums popped from the division FIFO through per-lane valid/ready. It returns saturated reciprocals, also through per-lane valid/ready, to be written back into the accumulator buffer.
- The upstream stage serves lanes round-robin, so there is no lane arbitration or reordering inside this block.

Parameters:
- NumDiv, 16, number of parallel divider lanes.
- AccWidth, 19, divisor (exponent sum) width.
- DivWidth, 16, quotient output width.
- DividendExp, 16, dividend is the constant 2^DividendExp.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous abort; returns all lanes to IDLE.
- div_inp_i  in  AccWidth  divisor, shared by all lanes.
- div_valid_i  in  NumDiv  per-lane request valid.
- div_ready_o  out  NumDiv  per-lane request ready.
- div_valid_o  out  NumDiv  per-lane result valid.
- div_ready_i  in  NumDiv  per-lane result ready.
- div_oup_o  out  NumDiv x DivWidth  per-lane quotient.
- busy_o  out  1  OR of all lanes not in IDLE.

Behaviour:
- Reset (async, active-low; clock clk_i):
  - all lanes IDLE; div_ready_o = all ones; div_valid_o = 0; div_oup_o = 0; busy_o = 0.
  - all internal remainder, quotient and counter registers = 0.
- Per-lane FSM, states IDLE, BUSY, DONE:
  - IDLE: div_ready_o[k] = 1. On div_valid_i[k] && div_ready_o[k], capture d = div_inp_i.
    - d == 0: go to DONE with quotient = all ones.
    - Otherwise: go to BUSY with remainder = 0, quotient = 0, bit counter = DividendExp.
  - BUSY: div_ready_o[k] = 0. One dividend bit per cycle, MSB first; dividend bit = 1 at index DividendExp, else 0.
    - r' = (r << 1) | bit.
    - If r' >= d: r = r' - d and shift in quotient bit 1; otherwise r = r' and shift in 0.
    - After DividendExp+1 iterations, i.e. when the counter reaches 0, go to DONE.
  - DONE: div_valid_o[k] = 1 and div_oup_o[k] is stable. On div_ready_i[k], go to IDLE.
    - div_ready_o[k] stays 0 in DONE; there is no same-cycle re-accept.
- Width rules:
  - remainder register is AccWidth+1 bits (no overflow on the shift).
  - internal quotient is DividendExp+1 bits.
  - output saturates to 2^DivWidth - 1 if any bit above DivWidth-1 is set.
  - divisor is unsigned.
- Latency (request handshake in cycle 0):
  - d != 0: BUSY during cycles 1..DividendExp+1; div_valid_o high from cycle DividendExp+2, i.e. 18 at defaults.
  - d == 0: div_valid_o high from cycle 1.
- Backpressure: div_valid_o and div_oup_o are held indefinitely while div_ready_i is low. The result must not change.
- div_valid_i asserted on a lane not in IDLE is ignored; that lane does not capture div_inp_i.
- Lanes are fully independent. Several lanes may be handshaking in the same cycle.
- div_oup_o of a lane not in DONE drives 0.
- clear_i:
  - Has priority over every handshake in the same cycle. All lanes go to IDLE next cycle; in-flight and pending results are dropped.
  - div_ready_o is 1 from the next cycle.
- Async reset mid-operation: outputs return to reset values immediately. No result is emitted afterwards for the aborted request.

Decomposition:
- ita_package constants: NumDiv, SoftmaxAccDataWidth (maps to AccWidth), DividerWidth (maps to DivWidth), new DivDividendExp.
- ita_package typedef: div_state_e {IDLE, BUSY, DONE}.
- Sub-module ita_serdiv_lane: one FSM plus datapath. The top instantiates NumDiv copies via generate and ORs the busy flags.

Test Plan:
- Lane 0, d=256 -> div_oup_o[0] = 256, div_valid_o[0] rising exactly 18 cycles after the handshake; div_ready_o[0] = 0 during cycles 1..17.
- d=3 -> 21845. d=65537 -> 0. d=1 -> 65535 (saturated from 65536). d=2 -> 32768.
- d=0 -> 65535 with div_valid_o high 1 cycle after the handshake.
- Backpressure: d=5, div_ready_i[2] low for 30 cycles -> div_oup_o[2] = 13107 held stable and div_valid_o[2] high throughout; a new div_valid_i[2] in that window is not accepted.
- Round-robin: 16 lanes fed d = 100..115 on consecutive cycles, results consumed in lane order -> each result equals floor(65536/d), e.g. lane 0 gives 655, lane 15 (d=115) gives 569; busy_o drops only after the last result pops.
- clear_i asserted 5 cycles into a d=7 division on lane 3 -> div_valid_o[3] never rises and div_ready_o[3] = 1 next cycle; a following d=7 request yields 9362.

Source files
------------

// File: rtl/ita_package.sv
// Shared constants and types for the softmax reciprocal divider bank.
// The division stage imports these so that lane count and widths stay consistent.
package ita_package;

    localparam int unsigned NumDiv              = 16;
    localparam int unsigned SoftmaxAccDataWidth = 19;
    localparam int unsigned DividerWidth        = 16;
    localparam int unsigned DivDividendExp      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ita_serdiv_lane.sv
// One radix-2 restoring serial divider lane computing a saturated floor(2^DividendExp / d).
// It has a request and a result valid/ready handshake, and clear aborts it back to IDLE.
module ita_serdiv_lane
    import ita_package::*;
#(
    parameter int unsigned AccWidth    = SoftmaxAccDataWidth,
    parameter int unsigned DivWidth    = DividerWidth,
    parameter int unsigned DividendExp = DivDividendExp
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [AccWidth-1:0] div_inp,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DivWidth-1:0] quotient,
    output logic                busy
);

    localparam int unsigned CntWidth = $clog2(DividendExp + 1);
    localparam logic [CntWidth-1:0] CntInit = CntWidth'(DividendExp);

    div_state_e state_reg, state_next;

    logic [AccWidth-1:0]  divisor_reg;
    logic [AccWidth:0]    rem_reg;
    logic [AccWidth:0]    rem_shift;
    logic [AccWidth:0]    rem_sub;
    logic [DividendExp:0] quo_reg;
    logic [CntWidth-1:0]  cnt_reg;
    logic                 accept;
    logic                 dividend_bit;
    logic                 quo_bit;

    assign accept       = (state_reg == IDLE) && in_valid;
    // The dividend is 2^DividendExp, so its only set bit is the first one shifted in.
    assign dividend_bit = (cnt_reg == CntInit);
    assign rem_shift    = {rem_reg[AccWidth-1:0], dividend_bit};
    assign quo_bit      = (rem_shift >= {1'b0, divisor_reg});
    assign rem_sub      = rem_shift - {1'b0, divisor_reg};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) state_next = (div_inp == '0) ? DONE : BUSY;
                BUSY: if (cnt_reg == '0) state_next = DONE;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
        end else if (!clear_i) begin
            if (accept) begin
                divisor_reg <= div_inp;
                rem_reg     <= '0;
                quo_reg     <= (div_inp == '0) ? '1 : '0;
                cnt_reg     <= CntInit;
            end else if (state_reg == BUSY) begin
                rem_reg <= quo_bit ? rem_sub : rem_shift;
                quo_reg <= {quo_reg[DividendExp-1:0], quo_bit};
                if (cnt_reg != '0) cnt_reg <= cnt_reg - CntWidth'(1);
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        quotient  = '0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                quotient  = (|quo_reg[DividendExp:DivWidth]) ? '1 : quo_reg[DivWidth-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ita_softmax_div.sv
// Bank of independent serial dividers that turns softmax row sums into saturated reciprocals.
// Lanes share the divisor bus and are served round-robin upstream, so no arbitration is needed here.
module ita_softmax_div
    import ita_package::*;
#(
    parameter int unsigned NumDiv_      = NumDiv,
    parameter int unsigned AccWidth     = SoftmaxAccDataWidth,
    parameter int unsigned DivWidth     = DividerWidth,
    parameter int unsigned DividendExp  = DivDividendExp
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic [AccWidth-1:0]                  div_inp_i,
    input  logic [NumDiv_-1:0]                   div_valid_i,
    output logic [NumDiv_-1:0]                   div_ready_o,
    output logic [NumDiv_-1:0]                   div_valid_o,
    input  logic [NumDiv_-1:0]                   div_ready_i,
    output logic [NumDiv_-1:0][DivWidth-1:0]     div_oup_o,
    output logic                                 busy_o
);

    logic [NumDiv_-1:0] lane_busy;

    for (genvar gi = 0; gi < NumDiv_; gi++) begin : gen_lane
        ita_serdiv_lane #(
            .AccWidth   (AccWidth),
            .DivWidth   (DivWidth),
            .DividendExp(DividendExp)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (clear_i),
            .div_inp  (div_inp_i),
            .in_valid (div_valid_i[gi]),
            .in_ready (div_ready_o[gi]),
            .out_valid(div_valid_o[gi]),
            .out_ready(div_ready_i[gi]),
            .quotient (div_oup_o[gi]),
            .busy     (lane_busy[gi])
        );
    end

    assign busy_o = |lane_busy;

endmodule

// File: tb/tb_ita_softmax_div.sv
// Self-checking bench for ita_softmax_div with directed scenarios and a randomized sweep.
// Expected quotients come from plain integer division of 2^16 with saturation.
module tb_ita_softmax_div;

    localparam int N  = 16;
    localparam int AW = 19;
    localparam int DW = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   clear_i;
    logic [AW-1:0]          div_inp_i;
    logic [N-1:0]           div_valid_i;
    logic [N-1:0]           div_ready_o;
    logic [N-1:0]           div_valid_o;
    logic [N-1:0]           div_ready_i;
    logic [N-1:0][DW-1:0]   div_oup_o;
    logic                   busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ita_softmax_div dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .div_inp_i  (div_inp_i),
        .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o),
        .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i),
        .div_oup_o  (div_oup_o),
        .busy_o     (busy_o)
    );

    function automatic int unsigned ref_q(input longint unsigned d);
        longint unsigned q;
        if (d == 0) return 65535;
        q = 65536 / d;
        return (q > 65535) ? 65535 : int'(q);
    endfunction

    // Issue one request on a lane, wait for its result, hold it for 'hold' cycles, then pop it.
    task automatic run_one(input int lane, input int unsigned d, input int hold,
                           output int unsigned q, output int lat, output bit timeout);
        @(negedge clk_i);
        div_inp_i         = AW'(d);
        div_valid_i[lane] = 1'b1;
        @(negedge clk_i);
        div_valid_i[lane] = 1'b0;
        lat = 1;
        timeout = 1'b0;
        while (!div_valid_o[lane]) begin
            if (lat > 40) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
        q = div_oup_o[lane];
        repeat (hold) @(negedge clk_i);
        div_ready_i[lane] = 1'b1;
        @(negedge clk_i);
        div_ready_i[lane] = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; div_inp_i = '0; div_valid_i = '0; div_ready_i = '0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (div_ready_o !== '1 || div_valid_o !== '0 || div_oup_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%h valid=%h oup_nonzero=%0d busy=%b, required ready=ffff valid=0 oup=0 busy=0",
                     div_ready_o, div_valid_o, (div_oup_o != '0), busy_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        $display("test_reset done");
    endtask

    task automatic test_latency();
        bit seen_err = 1'b0;
        @(negedge clk_i);
        div_inp_i = AW'(256);
        div_valid_i[0] = 1'b1;
        @(negedge clk_i);
        div_valid_i[0] = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (div_ready_o[0] !== 1'b0 || div_valid_o[0] !== 1'b0) seen_err = 1'b1;
            @(negedge clk_i);
        end
        checks++;
        if (seen_err) begin
            errors++;
            $display("FAIL latency_busy: lane0 ready/valid not 0/0 during cycles 1..17");
        end
        checks++;
        if (div_valid_o[0] !== 1'b1 || div_oup_o[0] !== 16'd256) begin
            errors++;
            $display("FAIL latency_done: cycle18 valid=%b oup=%0d, required valid=1 oup=256",
                     div_valid_o[0], div_oup_o[0]);
        end
        div_ready_i[0] = 1'b1;
        @(negedge clk_i);
        div_ready_i[0] = 1'b0;
        $display("test_latency d=256 q=%0d", div_oup_o[0]);
    endtask

    task automatic test_values();
        int unsigned dv[6] = '{3, 65537, 1, 2, 0, 524287};
        int unsigned q;
        int lat;
        bit to;
        foreach (dv[i]) begin
            run_one(i % N, dv[i], 0, q, lat, to);
            checks++;
            if (to || q !== ref_q(dv[i])) begin
                errors++;
                $display("FAIL value d=%0d: got %0d timeout=%b, required %0d", dv[i], q, to, ref_q(dv[i]));
            end
            if (dv[i] == 0) begin
                checks++;
                if (lat !== 1) begin
                    errors++;
                    $display("FAIL zero_latency: got %0d cycles, required 1", lat);
                end
            end
            $display("value d=%0d q=%0d lat=%0d", dv[i], q, lat);
        end
    endtask

    task automatic test_backpressure();
        bit bad_hold = 1'b0;
        bit bad_accept = 1'b0;
        int lat = 0;
        @(negedge clk_i);
        div_inp_i = AW'(5);
        div_valid_i[2] = 1'b1;
        @(negedge clk_i);
        div_valid_i[2] = 1'b0;
        while (!div_valid_o[2] && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        for (int c = 0; c < 30; c++) begin
            if (div_valid_o[2] !== 1'b1 || div_oup_o[2] !== 16'd13107) bad_hold = 1'b1;
            if (c >= 10 && c < 15) begin
                div_inp_i = AW'(9);
                div_valid_i[2] = 1'b1;
                if (div_ready_o[2] !== 1'b0) bad_accept = 1'b1;
            end else begin
                div_valid_i[2] = 1'b0;
            end
            @(negedge clk_i);
        end
        checks++;
        if (bad_hold) begin
            errors++;
            $display("FAIL backpressure_hold: lane2 valid=%b oup=%0d, required valid=1 oup=13107 throughout",
                     div_valid_o[2], div_oup_o[2]);
        end
        checks++;
        if (bad_accept) begin
            errors++;
            $display("FAIL backpressure_ready: lane2 ready was 1 while holding a result, required 0");
        end
        div_ready_i[2] = 1'b1;
        @(negedge clk_i);
        div_ready_i[2] = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (div_ready_o[2] !== 1'b1 || busy_o !== 1'b0 || div_valid_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_capture: ready=%b busy=%b valid=%b, required 1 0 0",
                     div_ready_o[2], busy_o, div_valid_o[2]);
        end
        $display("test_backpressure d=5 held 30 cycles");
    endtask

    task automatic test_round_robin();
        int wait_c;
        for (int k = 0; k < N; k++) begin
            @(negedge clk_i);
            div_inp_i = AW'(100 + k);
            div_valid_i = '0;
            div_valid_i[k] = 1'b1;
        end
        @(negedge clk_i);
        div_valid_i = '0;
        for (int k = 0; k < N; k++) begin
            wait_c = 0;
            while (!div_valid_o[k] && wait_c < 60) begin
                @(negedge clk_i);
                wait_c++;
            end
            checks++;
            if (div_valid_o[k] !== 1'b1 || div_oup_o[k] !== DW'(ref_q(100 + k))) begin
                errors++;
                $display("FAIL round_robin lane %0d: valid=%b oup=%0d, required valid=1 oup=%0d",
                         k, div_valid_o[k], div_oup_o[k], ref_q(100 + k));
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL round_robin_busy lane %0d: busy=%b before pop, required 1", k, busy_o);
            end
            $display("round_robin lane %0d d=%0d q=%0d", k, 100 + k, div_oup_o[k]);
            div_ready_i[k] = 1'b1;
            @(negedge clk_i);
            div_ready_i[k] = 1'b0;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL round_robin_idle: busy=%b after last pop, required 0", busy_o);
        end
    endtask

    task automatic test_clear();
        bit rose = 1'b0;
        int unsigned q;
        int lat;
        bit to;
        @(negedge clk_i);
        div_inp_i = AW'(7);
        div_valid_i[3] = 1'b1;
        @(negedge clk_i);
        div_valid_i[3] = 1'b0;
        repeat (4) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++;
        if (div_ready_o[3] !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: ready3=%b busy=%b, required 1 0", div_ready_o[3], busy_o);
        end
        for (int c = 0; c < 25; c++) begin
            if (div_valid_o[3]) rose = 1'b1;
            @(negedge clk_i);
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL clear_drop: lane3 valid rose after clear, required never");
        end
        run_one(3, 7, 2, q, lat, to);
        checks++;
        if (to || q !== 9362) begin
            errors++;
            $display("FAIL clear_rerun: got %0d timeout=%b, required 9362", q, to);
        end
        $display("test_clear rerun d=7 q=%0d", q);
    endtask

    task automatic test_async_reset();
        bit rose = 1'b0;
        @(negedge clk_i);
        div_inp_i = AW'(9);
        div_valid_i[1] = 1'b1;
        @(negedge clk_i);
        div_valid_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (div_ready_o !== '1 || div_valid_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%h valid=%h busy=%b, required ffff 0 0",
                     div_ready_o, div_valid_o, busy_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_i);
            if (div_valid_o[1] || busy_o) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL async_reset_drop: aborted request produced activity, required none");
        end
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back();
        int unsigned d;
        int wait_c = 0;
        d = $urandom_range(1, 2000);
        @(negedge clk_i);
        div_inp_i = AW'(d);
        div_valid_i = '1;
        @(negedge clk_i);
        div_valid_i = '0;
        while (div_valid_o !== '1 && wait_c < 40) begin
            @(negedge clk_i);
            wait_c++;
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (div_valid_o[k] !== 1'b1 || div_oup_o[k] !== DW'(ref_q(d))) begin
                errors++;
                $display("FAIL all_lanes lane %0d d=%0d: valid=%b oup=%0d, required 1 %0d",
                         k, d, div_valid_o[k], div_oup_o[k], ref_q(d));
            end
        end
        div_ready_i = '1;
        @(negedge clk_i);
        div_ready_i = '0;
        $display("test_back_to_back all lanes d=%0d q=%0d", d, ref_q(d));
    endtask

    task automatic test_random();
        int unsigned d, q;
        int lat, lane;
        bit to;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 20);
                1: d = $urandom_range(21, 70000);
                default: d = $urandom_range(0, 524287);
            endcase
            lane = $urandom_range(0, N - 1);
            run_one(lane, d, $urandom_range(0, 3), q, lat, to);
            checks++;
            if (to || q !== ref_q(d) || lat !== ((d == 0) ? 1 : 18)) begin
                errors++;
                $display("FAIL random lane %0d d=%0d: got q=%0d lat=%0d timeout=%b, required q=%0d lat=%0d",
                         lane, d, q, lat, to, ref_q(d), (d == 0) ? 1 : 18);
            end
            $display("random lane %0d d=%0d q=%0d lat=%0d", lane, d, q, lat);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_backpressure();
        test_round_robin();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
